// File: rtl/noc_pkg.sv
// ============================================================================
// Module  : noc_pkg
// Brief   : Shared router types: flit layout, output-port ids, FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int NOC_FLIT_W      = 23;
    localparam int PAYLOAD_MSB     = 22;
    localparam int PAYLOAD_LSB     = 7;
    localparam int ADDR_MSB        = 6;
    localparam int ADDR_LSB        = 3;
    localparam int TGT_MSB         = 2;
    localparam int TGT_LSB         = 0;

    localparam logic [2:0] PORT_ID_LOCAL = 3'd0;
    localparam logic [2:0] PORT_ID_NORTH = 3'd1;
    localparam logic [2:0] PORT_ID_EAST  = 3'd2;
    localparam logic [2:0] PORT_ID_SOUTH = 3'd3;
    localparam logic [2:0] PORT_ID_WEST  = 3'd4;

    typedef logic [NOC_FLIT_W-1:0] flit_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : N-way round-robin arbiter; pointer moves past the winner on advance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW:0]   idx;
    logic          found;

    // Scan from ptr upward, wrapping; idx never exceeds 2N-2 so one subtract folds it.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found              = 1'b1;
                gidx               = idx[PW-1:0];
                grant[idx[PW-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/output_port_arbiter.sv
// ============================================================================
// Module  : output_port_arbiter
// Brief   : Picks head flits targeting this port, pops one per cycle round-robin
//           and registers it onto the output link with valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module output_port_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int FLIT_W  = 23,
    parameter int TGT_W   = 3,
    parameter int PORT_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        pop,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    input  logic                     out_ready
);

    out_state_t          state;
    out_state_t          state_next;
    logic [NUM_IN-1:0]   req;
    logic [NUM_IN-1:0]   grant;
    logic [FLIT_W-1:0]   sel_flit;
    logic                can_load;
    logic                load;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_req
        assign req[i] = in_valid[i] &
                        (in_flit[i*FLIT_W +: TGT_W] == TGT_W'(PORT_ID));
    end

    rr_arbiter #(
        .N       (NUM_IN)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (load),
        .grant   (grant)
    );

    assign can_load = (state == ST_EMPTY) | out_ready;
    // Gate with rst so no FIFO is popped while the block is held in reset.
    assign load     = can_load & (|req) & rst;
    assign pop      = grant & {NUM_IN{load}};

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_flit = sel_flit | in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (load)               state_next = ST_FULL;
            ST_FULL:  if (out_ready && !load) state_next = ST_EMPTY;
            default:                          state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Data is not cleared on drain; out_valid alone qualifies it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_flit <= '0;
        end else if (load) begin
            out_flit <= sel_flit;
        end
    end

    assign out_valid = (state == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
// ============================================================================
// Module  : tb_output_port_arbiter
// Brief   : Scoreboard bench with modelled input FIFOs and a round-robin reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_port_arbiter;

    localparam int N   = 5;
    localparam int W   = 23;
    localparam int PID = 2;

    typedef logic [W-1:0] q_t[$];

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   in_flit;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     pop;
    logic [W-1:0]     out_flit;
    logic             out_valid;
    logic             out_ready;

    q_t          fifo [N];
    logic [W-1:0] sb[$];
    logic [W-1:0] last_loaded;
    int          pending  = -1;
    int          ptr      = 0;
    bit          model_full = 1'b0;
    bit          model_en = 1'b0;
    bit          drop_en  = 1'b0;
    int          errors   = 0;
    int          checks   = 0;

    always #5 clk = ~clk;

    output_port_arbiter #(
        .NUM_IN    (N),
        .FLIT_W    (W),
        .TGT_W     (3),
        .PORT_ID   (PID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .pop       (pop),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input int tgt);
        mk = {16'($urandom), 4'($urandom), 3'(tgt)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (fifo[i].size() > 0) begin
                in_flit[i*W +: W] = fifo[i][0];
                in_valid[i]       = 1'b1;
            end else begin
                in_flit[i*W +: W] = mk(($urandom % 2 == 0) ? PID : int'($urandom % 8));
                in_valid[i]       = 1'b0;
            end
        end
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) fifo[i].delete();
    endtask

    // Advance one clock; retire the FIFO head the reference decided to pop.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (pending >= 0) begin
            void'(fifo[pending].pop_front());
            pending = -1;
        end
        if (drop_en) begin
            for (int i = 0; i < N; i++) begin
                if (fifo[i].size() > 0 && fifo[i][0][2:0] != 3'(PID) && $urandom % 3 == 0)
                    void'(fifo[i].pop_front());
            end
        end
        drive();
    endtask

    // Reference: the output stage may accept when empty or being drained; the first
    // eligible FIFO head found scanning from ptr wins.
    always @(negedge clk) begin
        int        g;
        int        idx;
        bit        can_load;
        logic [N-1:0] ep;
        if (model_en) begin
            chk("out_valid", 32'(out_valid), 32'(model_full));
            if (model_full) chk("out_flit_held", 32'(out_flit), 32'(last_loaded));
            can_load = !model_full || out_ready;
            g = -1;
            if (can_load) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (g < 0 && fifo[idx].size() > 0 && fifo[idx][0][2:0] == 3'(PID))
                        g = idx;
                end
            end
            ep = (g >= 0) ? N'(1 << g) : '0;
            chk("pop", 32'(pop), 32'(ep));
            if (g >= 0) begin
                sb.push_back(fifo[g][0]);
                last_loaded = fifo[g][0];
                pending     = g;
                ptr         = (g + 1) % N;
                model_full  = 1'b1;
            end else if (out_ready) begin
                model_full  = 1'b0;
            end
        end
    end

    // Monitor: every flit accepted downstream must be the oldest expected one.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (model_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_flit", 32'(out_flit), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_flit", 32'(out_flit), 32'(e));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           seq [6];
        int           tgts [N];
        int           t;
        logic [N-1:0] popor;
        logic [W-1:0] held;

        seq  = '{1, 2, 4, 8, 16, 1};
        tgts = '{PID, 0, PID, 3, 4};

        // Reset held with every input requesting this port.
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = '1;
        for (int i = 0; i < N; i++) in_flit[i*W +: W] = mk(PID);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_flit", 32'(out_flit), 32'd0);
            chk("rst_pop", 32'(pop), 32'd0);
        end

        // Fairness: all inputs contend, pointer starts at 0.
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) repeat (2) fifo[i].push_back(mk(PID));
        drive();
        model_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cycle();
            @(negedge clk);
            chk("fair_pop", 32'(pop), 32'(seq[i]));
            if (i > 0) chk("fair_no_bubble", 32'(out_valid), 32'd1);
        end
        repeat (12) cycle();

        // Single flit: popped at t, visible at t+1.
        fifo[2].push_back(23'h00ABC2);
        drive();
        @(negedge clk);
        chk("single_pop", 32'(pop), 32'b00100);
        cycle();
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_flit", 32'(out_flit), 32'h00ABC2);
        cycle();

        // Target filter: only inputs whose target matches are ever popped.
        for (int i = 0; i < N; i++) repeat (3) fifo[i].push_back(mk(tgts[i]));
        drive();
        popor = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            popor = popor | pop;
            cycle();
        end
        chk("filter_popped", 32'(popor), 32'b00101);
        clear_fifos();
        drive();
        repeat (3) cycle();

        // Backpressure: hold for 4 cycles, then drain and refill in one cycle.
        for (int i = 0; i < 2; i++) repeat (3) fifo[i].push_back(mk(PID));
        drive();
        cycle();
        out_ready = 1'b0;
        held = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) held = out_flit;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pop", 32'(pop), 32'd0);
            chk("bp_hold", 32'(out_flit), 32'(held));
            cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_reload_onehot", 32'($onehot(pop)), 32'd1);
        cycle();
        @(negedge clk);
        chk("bp_refill_valid", 32'(out_valid), 32'd1);
        cycle();

        // Randomized traffic with mixed targets and random backpressure.
        drop_en = 1'b1;
        repeat (400) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if ($urandom % 4 == 0)
                    fifo[i].push_back(mk(($urandom % 5 == 0) ? int'($urandom % 8) : PID));
            end
            drive();
            out_ready = ($urandom % 4 != 0);
        end

        // Async reset while FULL.
        drop_en   = 1'b0;
        out_ready = 1'b0;
        cycle();
        clear_fifos();
        for (int i = 0; i < N; i++) repeat (2) fifo[i].push_back(mk(PID));
        drive();
        t = 0;
        while (t < 20) begin
            @(negedge clk);
            if (out_valid) break;
            t++;
        end
        chk("ar_wait_full", 32'(t < 20), 32'd1);
        cycle();
        model_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid_now", 32'(out_valid), 32'd0);
        chk("ar_flit_now", 32'(out_flit), 32'd0);
        chk("ar_pop_now", 32'(pop), 32'd0);
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("ar_hold_pop", 32'(pop), 32'd0);
            chk("ar_hold_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #2;
        rst        = 1'b1;
        sb.delete();
        pending    = -1;
        ptr        = 0;
        model_full = 1'b0;
        model_en   = 1'b1;
        @(negedge clk);
        chk("ar_first_grant", 32'(pop), 32'b00001);

        // Drain everything still queued.
        drop_en = 1'b1;
        repeat (60) cycle();
        @(negedge clk);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        model_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
